dmem_bridge: RTL and testbench

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_dmem_bridge.sv | 599 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: bridges the core data port to a single-outstanding backing-memory
// bus. Stores go through a FIFO write buffer. Loads are forwarded from the buffer
// when the word is still pending; otherwise they stall until a bus read completes.
module dmem_bridge #(
  parameter int unsigned DATA_WIDTH_P      = 32,
  parameter int unsigned DATA_ADDR_WIDTH_P = 32,
  parameter int unsigned WBUF_DEPTH_P      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_wr_en,
  input  logic                         i_rd_en,
  input  logic [DATA_ADDR_WIDTH_P-1:0] i_addr,
  input  logic [DATA_WIDTH_P-1:0]      i_wr_data,
  output logic [DATA_WIDTH_P-1:0]      o_rd_data,
  output logic                         o_stall,
  output logic                         o_bus_req,
  output logic                         o_bus_we,
  output logic [DATA_ADDR_WIDTH_P-1:0] o_bus_addr,
  output logic [DATA_WIDTH_P-1:0]      o_bus_wdata,
  input  logic                         i_bus_ack,
  input  logic [DATA_WIDTH_P-1:0]      i_bus_rdata
);

  localparam int unsigned WA_W  = DATA_ADDR_WIDTH_P - 2;
  localparam int unsigned PTR_W = (WBUF_DEPTH_P > 1) ? $clog2(WBUF_DEPTH_P) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUS  = 2'd1,
    RD_BUS  = 2'd2,
    RD_DONE = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  // Write buffer storage and bookkeeping
  logic [WA_W-1:0]          r_buf_addr [WBUF_DEPTH_P];
  logic [DATA_WIDTH_P-1:0]  r_buf_data [WBUF_DEPTH_P];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;

  // Registered bus request and captured read word
  logic                         r_bus_req;
  logic                         r_bus_we;
  logic [DATA_ADDR_WIDTH_P-1:0] r_bus_addr;
  logic [DATA_WIDTH_P-1:0]      r_bus_wdata;
  logic [DATA_WIDTH_P-1:0]      r_rd_data;

  logic                         w_bus_req_nxt;
  logic                         w_bus_we_nxt;
  logic [DATA_ADDR_WIDTH_P-1:0] w_bus_addr_nxt;
  logic [DATA_WIDTH_P-1:0]      w_bus_wdata_nxt;
  logic [DATA_WIDTH_P-1:0]      w_rd_data_nxt;

  logic [WA_W-1:0]          w_word_addr;
  logic                     w_unused_addr_lsb;
  logic                     w_store_req;
  logic                     w_load_req;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_bus_done;

  logic                     w_hit;
  logic [DATA_WIDTH_P-1:0]  w_hit_data;
  logic [PTR_W-1:0]         w_hit_idx;

  // Request decode; a simultaneous store and load is a store
  assign w_word_addr       = i_addr[DATA_ADDR_WIDTH_P-1:2];
  assign w_unused_addr_lsb = ^i_addr[1:0];
  assign w_store_req       = i_wr_en;
  assign w_load_req        = i_rd_en & ~i_wr_en;
  assign w_full            = (r_count == CNT_W'(WBUF_DEPTH_P));
  assign w_empty           = (r_count == '0);
  assign w_push            = w_store_req & ~w_full;
  assign w_bus_done        = r_bus_req & i_bus_ack;
  assign w_pop             = (r_state == WR_BUS) & w_bus_done;

  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;

  // Forwarding search: walk oldest to youngest so the youngest match wins
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    w_hit_idx  = r_rd_ptr;
    for (int unsigned k = 0; k < WBUF_DEPTH_P; k++) begin
      w_hit_idx = r_rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (r_buf_addr[w_hit_idx] == w_word_addr)) begin
        w_hit      = 1'b1;
        w_hit_data = r_buf_data[w_hit_idx];
      end
    end
  end

  // Next-state, next bus request, and core-facing outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_bus_req_nxt   = r_bus_req;
    w_bus_we_nxt    = r_bus_we;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_wdata_nxt = r_bus_wdata;
    w_rd_data_nxt   = r_rd_data;
    o_stall         = 1'b0;
    o_rd_data       = r_rd_data;

    case (r_state)
      IDLE: begin
        if (w_load_req && !w_hit) begin
          w_state_nxt    = RD_BUS;
          w_bus_req_nxt  = 1'b1;
          w_bus_we_nxt   = 1'b0;
          w_bus_addr_nxt = {w_word_addr, 2'b00};
        end else if (!w_empty) begin
          w_state_nxt     = WR_BUS;
          w_bus_req_nxt   = 1'b1;
          w_bus_we_nxt    = 1'b1;
          w_bus_addr_nxt  = {r_buf_addr[r_rd_ptr], 2'b00};
          w_bus_wdata_nxt = r_buf_data[r_rd_ptr];
        end
      end
      WR_BUS: begin
        if (w_bus_done) begin
          w_state_nxt   = IDLE;
          w_bus_req_nxt = 1'b0;
        end
      end
      RD_BUS: begin
        if (w_bus_done) begin
          w_state_nxt   = RD_DONE;
          w_bus_req_nxt = 1'b0;
          w_rd_data_nxt = i_bus_rdata;
        end
      end
      RD_DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt   = IDLE;
        w_bus_req_nxt = 1'b0;
      end
    endcase

    // A full buffer blocks stores regardless of a pop in the same cycle
    if (w_store_req && w_full) begin
      o_stall = 1'b1;
    end else if (w_load_req && (r_state != RD_DONE)) begin
      if (w_hit) begin
        o_rd_data = w_hit_data;
      end else begin
        o_stall = 1'b1;
      end
    end
  end

  // State, bus request, pointers and read register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_rd_data   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bus_req   <= w_bus_req_nxt;
      r_bus_we    <= w_bus_we_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
      r_rd_data   <= w_rd_data_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Buffer entry write; contents need no reset since validity lives in r_count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_addr[r_wr_ptr] <= w_word_addr;
      r_buf_data[r_wr_ptr] <= i_wr_data;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed scenarios plus randomized store/load traffic checked
// against a flat-memory model of what the core should observe.
`timescale 1ns/1ps
module tb_dmem_bridge;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          i_wr_en;
  logic          i_rd_en;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wr_data;
  logic [DW-1:0] o_rd_data;
  logic          o_stall;
  logic          o_bus_req;
  logic          o_bus_we;
  logic [AW-1:0] o_bus_addr;
  logic [DW-1:0] o_bus_wdata;
  logic          i_bus_ack;
  logic [DW-1:0] i_bus_rdata;

  int n_tests;
  int n_fail;

  bit   ack_en;
  int   ack_delay;
  logic force_ack;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          cycles;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] bmem [logic [29:0]];

  dmem_bridge #(
    .DATA_WIDTH_P      (DW),
    .DATA_ADDR_WIDTH_P (AW),
    .WBUF_DEPTH_P      (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_wr_en     (i_wr_en),
    .i_rd_en     (i_rd_en),
    .i_addr      (i_addr),
    .i_wr_data   (i_wr_data),
    .o_rd_data   (o_rd_data),
    .o_stall     (o_stall),
    .o_bus_req   (o_bus_req),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wdata (o_bus_wdata),
    .i_bus_ack   (i_bus_ack),
    .i_bus_rdata (i_bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(logic [29:0] w);
    return (32'(w) * 32'h9E37_79B9) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] back_rd(logic [29:0] w);
    return bmem.exists(w) ? bmem[w] : init_word(w);
  endfunction

  function automatic int count_writes();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].we) n++;
    return n;
  endfunction

  // Backing-memory responder: acks after ack_delay request cycles, checks hold stability
  initial begin
    int          cyc;
    logic [31:0] h_addr;
    logic [31:0] h_data;
    logic        h_we;
    cyc = 0;
    h_addr = '0;
    h_data = '0;
    h_we = 1'b0;
    i_bus_ack = 1'b0;
    i_bus_rdata = '0;
    forever begin
      @(posedge clk);
      #3;
      i_bus_rdata = $urandom;
      if (o_bus_req === 1'b1) begin
        if (cyc == 0) begin
          h_addr = o_bus_addr;
          h_data = o_bus_wdata;
          h_we   = o_bus_we;
          n_tests++;
          if (o_bus_addr[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL bus_addr_align: got %h want low bits 00", o_bus_addr);
          end
        end else begin
          n_tests++;
          if ({o_bus_we, o_bus_addr, o_bus_wdata} !== {h_we, h_addr, h_data}) begin
            n_fail++;
            $display("FAIL bus_hold: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                     o_bus_we, o_bus_addr, o_bus_wdata, h_we, h_addr, h_data);
          end
        end
        cyc++;
        if (ack_en && (cyc >= ack_delay)) begin
          i_bus_ack = 1'b1;
          if (h_we) bmem[h_addr[31:2]] = h_data;
          else      i_bus_rdata = back_rd(h_addr[31:2]);
          log_q.push_back('{we: h_we, addr: h_addr, data: h_data, cycles: cyc});
          cyc = 0;
        end else begin
          i_bus_ack = force_ack;
        end
      end else begin
        cyc = 0;
        i_bus_ack = force_ack;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    i_addr = '0;
    i_wr_data = '0;
  endtask

  task automatic wait_log(input int n, input int bound, output bit to);
    to = 1'b1;
    for (int c = 0; c < bound; c++) begin
      if (log_q.size() >= n) begin
        to = 1'b0;
        break;
      end
      step();
    end
  endtask

  // Hold a store until accepted (called at +1 after an edge, returns at +1)
  task automatic core_store(input logic [31:0] addr, input logic [31:0] data,
                            input bit both, output bit to);
    i_wr_en = 1'b1;
    i_rd_en = both;
    i_addr = addr;
    i_wr_data = data;
    to = 1'b1;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (o_stall === 1'b0) begin
        to = 1'b0;
        step();
        break;
      end
      step();
    end
    idle_inputs();
  endtask

  // Hold a load until the bridge returns data
  task automatic core_load(input logic [31:0] addr, output logic [31:0] data, output bit to);
    i_wr_en = 1'b0;
    i_rd_en = 1'b1;
    i_addr = addr;
    data = '0;
    to = 1'b1;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (o_stall === 1'b0) begin
        data = o_rd_data;
        to = 1'b0;
        step();
        break;
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({o_bus_req, o_bus_we} !== 2'b00) begin
      n_fail++; $display("FAIL reset_req_we: got %b%b want 00", o_bus_req, o_bus_we);
    end
    n_tests++;
    if (o_bus_addr !== 32'h0 || o_bus_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr_wdata: got %h/%h want 0/0", o_bus_addr, o_bus_wdata);
    end
    n_tests++;
    if (o_rd_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd_data: got %h want 0", o_rd_data);
    end
    n_tests++;
    if (o_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b want 0", o_stall);
    end
    step();
  endtask

  task automatic test_store_drain();
    int base;
    bit to;
    ack_en = 1'b1;
    ack_delay = 3;
    base = log_q.size();
    i_wr_en = 1'b1;
    i_addr = 32'h0000_0010;
    i_wr_data = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (o_stall !== 1'b0) begin
      n_fail++; $display("FAIL store_no_stall: got %b want 0", o_stall);
    end
    step();
    idle_inputs();
    wait_log(base + 1, 30, to);
    n_tests++;
    if (to) begin
      n_fail++; $display("FAIL store_drain_timeout: got %0d txns want %0d", log_q.size(), base + 1);
    end else begin
      n_tests++;
      if (log_q[base].we !== 1'b1 || log_q[base].addr !== 32'h10 ||
          log_q[base].data !== 32'hDEAD_BEEF || log_q[base].cycles != 3) begin
        n_fail++;
        $display("FAIL store_bus_write: got we=%b a=%h d=%h cyc=%0d want we=1 a=10 d=deadbeef cyc=3",
                 log_q[base].we, log_q[base].addr, log_q[base].data, log_q[base].cycles);
      end
    end
    repeat (5) step();
    n_tests++;
    if (log_q.size() != base + 1 || o_bus_req !== 1'b0) begin
      n_fail++; $display("FAIL store_buffer_empty: got txns=%0d req=%b want %0d/0",
                         log_q.size(), o_bus_req, base + 1);
    end
  endtask

  task automatic test_full_stall();
    int base;
    int waited;
    bit to;
    ack_en = 1'b0;
    base = log_q.size();
    for (int i = 0; i < 4; i++) begin
      i_wr_en = 1'b1;
      i_addr = 32'h100 + 32'(4 * i);
      i_wr_data = 32'h1111_0000 + 32'(i);
      #1;
      n_tests++;
      if (o_stall !== 1'b0) begin
        n_fail++; $display("FAIL full_enqueue%0d: got stall %b want 0", i, o_stall);
      end
      step();
    end
    i_addr = 32'h110;
    i_wr_data = 32'h1111_0004;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (o_stall !== 1'b1) begin
        n_fail++; $display("FAIL full_stall_c%0d: got %b want 1", c, o_stall);
      end
      step();
    end
    ack_en = 1'b1;
    ack_delay = 1;
    waited = 0;
    to = 1'b1;
    for (int c = 0; c < 50; c++) begin
      #3;
      if (o_stall === 1'b0) begin
        to = 1'b0;
        break;
      end
      waited++;
      step();
    end
    n_tests++;
    if (to || waited != 1) begin
      n_fail++; $display("FAIL full_release: got stalled %0d cycles after ack enable want 1", waited);
    end
    step();
    idle_inputs();
    wait_log(base + 5, 100, to);
    repeat (10) step();
    n_tests++;
    if (log_q.size() != base + 5) begin
      n_fail++; $display("FAIL full_write_count: got %0d want %0d", log_q.size() - base, 5);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (log_q[base+i].we !== 1'b1 || log_q[base+i].addr !== 32'h100 + 32'(4 * i) ||
            log_q[base+i].data !== 32'h1111_0000 + 32'(i)) begin
          n_fail++; $display("FAIL full_write_order%0d: got we=%b a=%h d=%h want we=1 a=%h d=%h", i,
                             log_q[base+i].we, log_q[base+i].addr, log_q[base+i].data,
                             32'h100 + 32'(4 * i), 32'h1111_0000 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_forward();
    int base;
    bit to;
    ack_en = 1'b0;
    base = log_q.size();
    i_wr_en = 1'b1;
    i_addr = 32'h20;
    i_wr_data = 32'h1;
    step();
    i_wr_data = 32'h2;
    step();
    i_wr_en = 1'b0;
    i_rd_en = 1'b1;
    i_addr = 32'h23;
    #1;
    n_tests++;
    if (o_stall !== 1'b0 || o_rd_data !== 32'h2) begin
      n_fail++; $display("FAIL forward_youngest: got stall=%b data=%h want 0/00000002", o_stall, o_rd_data);
    end
    step();
    idle_inputs();
    ack_en = 1'b1;
    ack_delay = 1;
    wait_log(base + 2, 60, to);
    repeat (5) step();
    n_tests++;
    if (log_q.size() != base + 2) begin
      n_fail++; $display("FAIL forward_txn_count: got %0d want 2 (no bus read)", log_q.size() - base);
    end else begin
      n_tests++;
      if (log_q[base].we !== 1'b1 || log_q[base].data !== 32'h1 ||
          log_q[base+1].we !== 1'b1 || log_q[base+1].data !== 32'h2 ||
          log_q[base+1].addr !== 32'h20) begin
        n_fail++; $display("FAIL forward_writes: got %b:%h %b:%h want 1:1 1:2",
                           log_q[base].we, log_q[base].data, log_q[base+1].we, log_q[base+1].data);
      end
    end
  endtask

  task automatic test_load_miss();
    int base;
    ack_en = 1'b1;
    ack_delay = 2;
    bmem[30'h10] = 32'hCAFE_F00D;
    base = log_q.size();
    i_rd_en = 1'b1;
    i_addr = 32'h40;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_tests++;
      if (o_stall !== ((c < 3) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL miss_stall_c%0d: got %b want %b", c, o_stall, (c < 3) ? 1'b1 : 1'b0);
      end
      if (c == 3) begin
        n_tests++;
        if (o_rd_data !== 32'hCAFE_F00D) begin
          n_fail++; $display("FAIL miss_rd_data: got %h want cafef00d", o_rd_data);
        end
      end
      step();
    end
    idle_inputs();
    #1;
    n_tests++;
    if (o_rd_data !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL miss_rd_hold: got %h want cafef00d", o_rd_data);
    end
    n_tests++;
    if (log_q.size() != base + 1) begin
      n_fail++; $display("FAIL miss_read_count: got %0d want 1", log_q.size() - base);
    end else if (log_q[base].we !== 1'b0 || log_q[base].addr !== 32'h40 || log_q[base].cycles != 2) begin
      n_fail++; $display("FAIL miss_read_txn: got we=%b a=%h cyc=%0d want we=0 a=40 cyc=2",
                         log_q[base].we, log_q[base].addr, log_q[base].cycles);
    end
    step();
  endtask

  task automatic test_miss_during_write();
    int          base;
    bit          to;
    logic [31:0] got;
    logic        exp_we [4];
    logic [31:0] exp_a  [4];
    exp_we = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_a  = '{32'h200, 32'h300, 32'h204, 32'h208};
    ack_en = 1'b0;
    base = log_q.size();
    for (int i = 0; i < 3; i++) begin
      i_wr_en = 1'b1;
      i_addr = 32'h200 + 32'(4 * i);
      i_wr_data = 32'hA000_0000 + 32'(i);
      step();
    end
    idle_inputs();
    i_rd_en = 1'b1;
    i_addr = 32'h300;
    #1;
    n_tests++;
    if (o_stall !== 1'b1 || o_bus_req !== 1'b1 || o_bus_we !== 1'b1 || o_bus_addr !== 32'h200) begin
      n_fail++; $display("FAIL mdw_inflight: got stall=%b req=%b we=%b a=%h want 1/1/1/200",
                         o_stall, o_bus_req, o_bus_we, o_bus_addr);
    end
    step();
    ack_en = 1'b1;
    ack_delay = 2;
    core_load(32'h300, got, to);
    n_tests++;
    if (to || got !== init_word(30'hC0)) begin
      n_fail++; $display("FAIL mdw_load_data: got %h timeout=%b want %h", got, to, init_word(30'hC0));
    end
    wait_log(base + 4, 100, to);
    repeat (10) step();
    n_tests++;
    if (log_q.size() != base + 4) begin
      n_fail++; $display("FAIL mdw_txn_count: got %0d want 4", log_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (log_q[base+i].we !== exp_we[i] || log_q[base+i].addr !== exp_a[i]) begin
          n_fail++; $display("FAIL mdw_order%0d: got we=%b a=%h want we=%b a=%h", i,
                             log_q[base+i].we, log_q[base+i].addr, exp_we[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_txn();
    int base;
    bit to;
    ack_en = 1'b0;
    i_rd_en = 1'b1;
    i_addr = 32'h80;
    to = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (o_bus_req === 1'b1 && o_bus_we === 1'b0) begin
        to = 1'b0;
        break;
      end
      step();
    end
    n_tests++;
    if (to) begin
      n_fail++; $display("FAIL rst_rd_bus_reach: got req=%b we=%b want 1/0", o_bus_req, o_bus_we);
    end
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    force_ack = 1'b1;
    #1;
    n_tests++;
    if (o_bus_req !== 1'b0 || o_rd_data !== 32'h0 || o_stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_abandon: got req=%b rd=%h stall=%b want 0/0/0", o_bus_req, o_rd_data, o_stall);
    end
    step();
    force_ack = 1'b0;
    #1;
    n_tests++;
    if (o_bus_req !== 1'b0 || o_rd_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_late_ack: got req=%b rd=%h want 0/0", o_bus_req, o_rd_data);
    end
    step();
    base = log_q.size();
    i_wr_en = 1'b1;
    i_addr = 32'h400;
    i_wr_data = 32'h1;
    step();
    i_addr = 32'h404;
    i_wr_data = 32'h2;
    step();
    idle_inputs();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ack_en = 1'b1;
    ack_delay = 1;
    repeat (15) step();
    n_tests++;
    if (log_q.size() != base || o_bus_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_discard: got writes=%0d req=%b want 0/0", log_q.size() - base, o_bus_req);
    end
  endtask

  task automatic test_random();
    logic [31:0] core_mem [logic [29:0]];
    txn_t        exp_w[$];
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] got;
    logic [31:0] exp;
    logic [29:0] w;
    int          op;
    int          j;
    bit          to;
    ack_en = 1'b1;
    log_q.delete();
    for (int i = 0; i < 150; i++) begin
      ack_delay = int'($urandom_range(1, 4));
      op = int'($urandom_range(0, 9));
      addr = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      w = addr[31:2];
      if (op <= 3 || op == 8) begin
        data = $urandom;
        core_store(addr, data, op == 8, to);
        n_tests++;
        if (to) begin
          n_fail++; $display("FAIL rnd_store_timeout: op %0d addr %h stall stuck want accept", i, addr);
        end else begin
          core_mem[w] = data;
          exp_w.push_back('{we: 1'b1, addr: {w, 2'b00}, data: data, cycles: 0});
        end
      end else if (op <= 7) begin
        core_load(addr, got, to);
        exp = core_mem.exists(w) ? core_mem[w] : init_word(w);
        n_tests++;
        if (to || got !== exp) begin
          n_fail++; $display("FAIL rnd_load: op %0d addr %h got %h timeout=%b want %h", i, addr, got, to, exp);
        end
      end else begin
        step();
      end
    end
    to = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (count_writes() >= exp_w.size()) begin
        to = 1'b0;
        break;
      end
      step();
    end
    repeat (10) step();
    n_tests++;
    if (to || count_writes() != exp_w.size()) begin
      n_fail++; $display("FAIL rnd_write_count: got %0d want %0d", count_writes(), exp_w.size());
    end else begin
      j = 0;
      foreach (log_q[k]) begin
        if (log_q[k].we) begin
          n_tests++;
          if (log_q[k].addr !== exp_w[j].addr || log_q[k].data !== exp_w[j].data) begin
            n_fail++; $display("FAIL rnd_write%0d: got a=%h d=%h want a=%h d=%h", j,
                               log_q[k].addr, log_q[k].data, exp_w[j].addr, exp_w[j].data);
          end
          j++;
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    ack_en = 1'b1;
    ack_delay = 1;
    force_ack = 1'b0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_store_drain();
    test_full_stall();
    test_forward();
    test_load_miss();
    test_miss_during_write();
    test_reset_mid_txn();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
